// File: rtl/speck_uart_ctrl.sv
`default_nettype none
// ==== speck_uart_ctrl : UART command parser / Speck core sequencer ====
// ==== rev 1.0 ====
module speck_uart_ctrl #(
  parameter int         KEY_BYTES   = 16,
  parameter int         BLOCK_BYTES = 8,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] CMD_KEY     = 8'h4B,
  parameter logic [7:0] CMD_ENC     = 8'h45
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_busy,
  output logic [KEY_BYTES*8-1:0]   core_key,
  output logic [BLOCK_BYTES*8-1:0] core_pt,
  output logic                     core_start,
  input  logic [BLOCK_BYTES*8-1:0] core_ct,
  input  logic                     core_done,
  output logic                     key_loaded,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int KW   = KEY_BYTES * 8;
  localparam int BW   = BLOCK_BYTES * 8;
  localparam int MAXB = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] C_KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] C_PT_LAST  = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] C_BLOCK    = CW'(BLOCK_BYTES);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    C_ACK      = 8'h06;
  localparam logic [7:0]    C_NAK      = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_KEY   = 3'd1,
    S_GET_PT    = 3'd2,
    S_START     = 3'd3,
    S_WAIT_CORE = 3'd4,
    S_SEND      = 3'd5,
    S_SEND_HI   = 3'd6,
    S_SEND_LO   = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [BW-1:0]   sr_q, sr_d;
  logic [KW-1:0]   key_q, key_d;
  logic [BW-1:0]   pt_q, pt_d;
  logic            key_loaded_q, key_loaded_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            core_start_q, core_start_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    sr_d         = sr_q;
    key_d        = key_q;
    pt_d         = pt_q;
    key_loaded_d = key_loaded_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    core_start_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cnt_d = '0;
          tmo_d = '0;
          if (rx_data == CMD_KEY) begin
            // The key is rewritten in place, so it is invalid until the frame completes.
            key_loaded_d = 1'b0;
            state_d      = S_GET_KEY;
          end else if ((rx_data == CMD_ENC) && key_loaded_q) begin
            state_d = S_GET_PT;
          end else begin
            frame_err_d        = (rx_data != CMD_ENC);
            sr_d               = '0;
            sr_d[BW-1 -: 8]    = C_NAK;
            cnt_d              = C_ONE;
            state_d            = S_SEND;
          end
        end
      end

      S_GET_KEY, S_GET_PT: begin
        if (rx_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + C_ONE;
          if (state_q == S_GET_KEY) begin
            key_d = {key_q[KW-9:0], rx_data};
            if (cnt_q == C_KEY_LAST) begin
              key_loaded_d    = 1'b1;
              sr_d            = '0;
              sr_d[BW-1 -: 8] = C_ACK;
              cnt_d           = C_ONE;
              state_d         = S_SEND;
            end
          end else begin
            pt_d = {pt_q[BW-9:0], rx_data};
            if (cnt_q == C_PT_LAST) begin
              state_d = S_START;
            end
          end
        end else if (tmo_q == C_TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_START: begin
        core_start_d = 1'b1;
        state_d      = S_WAIT_CORE;
      end

      S_WAIT_CORE: begin
        if (core_done) begin
          sr_d    = core_ct;
          cnt_d   = C_BLOCK;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = sr_q[BW-1 -: 8];
          tx_valid_d = 1'b1;
          state_d    = S_SEND_HI;
        end
      end

      // Wait for the transmitter to acknowledge the strobe before looking for its idle edge.
      S_SEND_HI: begin
        if (tx_busy) begin
          state_d = S_SEND_LO;
        end
      end

      S_SEND_LO: begin
        if (!tx_busy) begin
          sr_d    = sr_q << 8;
          cnt_d   = cnt_q - C_ONE;
          state_d = (cnt_q == C_ONE) ? S_IDLE : S_SEND;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      sr_q         <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      key_loaded_q <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      core_start_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      sr_q         <= sr_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      key_loaded_q <= key_loaded_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      core_start_q <= core_start_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign core_key   = key_q;
  assign core_pt    = pt_q;
  assign core_start = core_start_q;
  assign key_loaded = key_loaded_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_speck_uart_ctrl.sv
`default_nettype none
// ==== tb_speck_uart_ctrl : self-checking bench for speck_uart_ctrl ====
// ==== rev 1.0 ====
module tb_speck_uart_ctrl;

  localparam int TMO = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_busy;
  logic [127:0] core_key;
  logic [63:0]  core_pt;
  logic         core_start;
  logic [63:0]  core_ct = '0;
  logic         core_done = 1'b0;
  logic         key_loaded;
  logic         busy;
  logic         frame_err;

  speck_uart_ctrl #(
    .KEY_BYTES(16), .BLOCK_BYTES(8), .TIMEOUT_CYC(TMO),
    .CMD_KEY(8'h4B), .CMD_ENC(8'h45)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .core_key(core_key), .core_pt(core_pt), .core_start(core_start),
    .core_ct(core_ct), .core_done(core_done),
    .key_loaded(key_loaded), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for a random 4..12 cycles after each start strobe.
  logic hold_busy = 1'b0;
  int   mbusy_cnt = 0;
  assign tx_busy = hold_busy | (mbusy_cnt != 0);
  always @(posedge clk) begin
    if (mbusy_cnt != 0) mbusy_cnt <= mbusy_cnt - 1;
    else if (tx_valid)  mbusy_cnt <= 4 + int'($urandom_range(8, 0));
  end

  localparam logic [127:0] KNOWN_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  KNOWN_PT  = 64'h3b726574_7475432d;
  localparam logic [63:0]  KNOWN_CT  = 64'h8c6fa548_454e028b;

  function automatic logic [63:0] core_fn(input logic [127:0] k, input logic [63:0] p);
    if (k == KNOWN_KEY && p == KNOWN_PT) return KNOWN_CT;
    return (p * 64'h9E3779B97F4A7C15) ^ k[63:0] ^ k[127:64];
  endfunction

  // Core model: answers each start after 30..50 cycles.
  logic        cpend = 1'b0;
  int          cdelay = 0;
  logic [63:0] cct = '0;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      cpend  <= 1'b1;
      cdelay <= 30 + int'($urandom_range(20, 0));
      cct    <= core_fn(core_key, core_pt);
    end else if (cpend) begin
      if (cdelay == 0) begin
        cpend     <= 1'b0;
        core_done <= 1'b1;
        core_ct   <= cct;
      end else begin
        cdelay <= cdelay - 1;
      end
    end
  end

  // Output monitor.
  logic [7:0] got[$];
  int   start_cnt = 0, ferr_cnt = 0, viol = 0;
  int   start_cyc = 0, done_cyc = 0, first_tx_cyc = 0, ferr_cyc = 0;
  logic prev_v = 1'b0, awaiting = 1'b0;
  always @(negedge clk) begin
    if (tx_valid) got.push_back(tx_data);
    viol   <= viol + int'(tx_valid && tx_busy) + int'(tx_valid && prev_v);
    prev_v <= tx_valid;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if (core_done) begin
      done_cyc <= cyc;
      awaiting <= 1'b1;
    end else if (tx_valid && awaiting) begin
      first_tx_cyc <= cyc;
      awaiting     <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;
  int last_rx_cyc = 0;
  int rd_idx = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] m_key = '0;
  logic         m_loaded = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag);
    int n;
    int ngot;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || tx_busy) && n < 5000);
    check({tag, " idle"}, 128'(n < 5000), 128'(1));
    ngot = got.size() - rd_idx;
    check({tag, " nbytes"}, 128'(ngot), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ngot; i++)
      check({tag, " byte"}, 128'(got[rd_idx + i]), 128'(exp_q[i]));
    rd_idx = got.size();
    exp_q.delete();
    check({tag, " key"}, core_key, m_key);
    check({tag, " key_loaded"}, 128'(key_loaded), 128'(m_loaded));
  endtask

  task automatic do_key(input logic [127:0] k);
    send_byte(8'h4B, $urandom_range(3, 0));
    for (int i = 0; i < 16; i++) begin
      send_byte(k[127 - 8*i -: 8], $urandom_range(3, 0));
      m_key = {m_key[119:0], k[127 - 8*i -: 8]};
    end
    m_loaded = 1'b1;
    exp_q.push_back(8'h06);
    expect_frame("key");
  endtask

  task automatic do_enc(input logic [63:0] pt, input bit junk, input bit hold);
    int s0;
    int rxc;
    logic [63:0] ct;
    s0 = start_cnt;
    send_byte(8'h45, $urandom_range(3, 0));
    if (!m_loaded) begin
      exp_q.push_back(8'h15);
      expect_frame("enc_nokey");
      check("enc_nokey starts", 128'(start_cnt - s0), 128'(0));
      return;
    end
    for (int i = 0; i < 8; i++)
      send_byte(pt[63 - 8*i -: 8], (i == 7) ? 0 : $urandom_range(3, 0));
    rxc = last_rx_cyc;
    if (hold) hold_busy = 1'b1;
    if (junk) for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    ct = core_fn(m_key, pt);
    for (int i = 0; i < 8; i++) exp_q.push_back(ct[63 - 8*i -: 8]);
    if (hold) begin
      repeat (500) @(negedge clk);
      check("hold no tx", 128'(got.size() - rd_idx), 128'(0));
      check("hold busy", 128'(busy), 128'(1));
      hold_busy = 1'b0;
    end
    expect_frame("enc");
    check("enc starts", 128'(start_cnt - s0), 128'(1));
    check("enc start latency", 128'(start_cyc - rxc), 128'(2));
    check("enc pt", 128'(core_pt), 128'(pt));
    if (!hold) check("enc tx latency", 128'(first_tx_cyc - done_cyc), 128'(2));
  endtask

  task automatic do_unknown(input logic [7:0] op);
    int f0;
    f0 = ferr_cnt;
    send_byte(op, 0);
    exp_q.push_back(8'h15);
    expect_frame("unknown");
    check("unknown frame_err", 128'(ferr_cnt - f0), 128'(1));
  endtask

  task automatic do_timeout(input logic [7:0] op, input int nbytes);
    int f0, s0, rxc, n;
    logic [7:0] b;
    f0 = ferr_cnt;
    s0 = start_cnt;
    send_byte(op, 0);
    if (op == 8'h4B) m_loaded = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      send_byte(b, 0);
      if (op == 8'h4B) m_key = {m_key[119:0], b};
    end
    rxc = last_rx_cyc;
    n = 0;
    while (ferr_cnt == f0 && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("tmo frame_err", 128'(ferr_cnt - f0), 128'(1));
    check("tmo delay", 128'((ferr_cyc - rxc) >= TMO && (ferr_cyc - rxc) <= TMO + 2), 128'(1));
    check("tmo idle", 128'(busy), 128'(0));
    check("tmo starts", 128'(start_cnt - s0), 128'(0));
    check("tmo no tx", 128'(got.size() - rd_idx), 128'(0));
    check("tmo key", core_key, m_key);
    check("tmo key_loaded", 128'(key_loaded), 128'(m_loaded));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " tx_data"}, 128'(tx_data), 128'(0));
    check({tag, " tx_valid"}, 128'(tx_valid), 128'(0));
    check({tag, " core_start"}, 128'(core_start), 128'(0));
    check({tag, " core_key"}, core_key, 128'(0));
    check({tag, " core_pt"}, 128'(core_pt), 128'(0));
    check({tag, " key_loaded"}, 128'(key_loaded), 128'(0));
    check({tag, " busy"}, 128'(busy), 128'(0));
    check({tag, " frame_err"}, 128'(frame_err), 128'(0));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] op;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset");

    do_enc(64'h0, 1'b0, 1'b0);
    do_unknown(8'h5A);
    do_key(KNOWN_KEY);
    check("known key", core_key, KNOWN_KEY);
    do_enc(KNOWN_PT, 1'b0, 1'b0);
    do_timeout(8'h45, 2);
    do_enc({$urandom, $urandom}, 1'b0, 1'b0);
    do_enc({$urandom, $urandom}, 1'b1, 1'b1);
    do_timeout(8'h4B, 5);
    do_enc({$urandom, $urandom}, 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      r = int'($urandom_range(5, 0));
      case (r)
        0:       do_key({$urandom, $urandom, $urandom, $urandom});
        1, 2:    do_enc({$urandom, $urandom}, 1'($urandom), 1'b0);
        3: begin
          do op = 8'($urandom); while (op == 8'h4B || op == 8'h45);
          do_unknown(op);
        end
        4:       do_timeout(8'h4B, int'($urandom_range(15, 1)));
        default: begin
          if (!m_loaded) do_key({$urandom, $urandom, $urandom, $urandom});
          do_enc({$urandom, $urandom}, 1'b1, 1'b0);
        end
      endcase
    end

    if (!m_loaded) do_key(KNOWN_KEY);
    send_byte(8'h45, 0);
    for (int i = 0; i < 8; i++) send_byte(KNOWN_PT[63 - 8*i -: 8], 0);
    n = 0;
    while (!tx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pre-reset tx seen", 128'(tx_valid), 128'(1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    m_key    = '0;
    m_loaded = 1'b0;
    rd_idx   = got.size();
    exp_q.delete();
    do_enc({$urandom, $urandom}, 1'b0, 1'b0);

    check("handshake violations", 128'(viol), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/speck_uart_ctrl.md
Name: speck_uart_ctrl

Overview:
Byte-level command sequencer between the UART RX/TX pair and the Speck block-cipher core. It parses a small command protocol from received bytes and assembles key and plaintext registers MSB-first. It starts the core, waits for completion, then serializes the ciphertext back through the UART transmitter while obeying its busy handshake. One instance sits at the top level between uart_rx/uart_tx and the Speck core.

Parameters:
KEY_BYTES, 16, key length in bytes (Speck64/128)
BLOCK_BYTES, 8, block length in bytes
TIMEOUT_CYC, 1_000_000, maximum idle clocks between bytes of one frame before the frame is aborted
CMD_KEY, 8'h4B, opcode 'K': KEY_BYTES key bytes follow
CMD_ENC, 8'h45, opcode 'E': BLOCK_BYTES plaintext bytes follow

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from uart_rx
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to uart_tx
tx_valid  out  1  one-cycle start strobe to uart_tx
tx_busy  in  1  uart_tx busy
core_key  out  KEY_BYTES*8  key to Speck core
core_pt  out  BLOCK_BYTES*8  plaintext to Speck core
core_start  out  1  one-cycle start pulse
core_ct  in  BLOCK_BYTES*8  ciphertext from core
core_done  in  1  one-cycle done pulse, core_ct valid
key_loaded  out  1  a complete key has been received since reset
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse on timeout or unknown opcode

Behaviour:
- Reset (rst=0, async): state IDLE; tx_data=0, tx_valid=0, core_start=0, core_key=0, core_pt=0, key_loaded=0, busy=0, frame_err=0; byte counter, timeout counter and ct shift register cleared. Reset mid-frame or mid-send aborts immediately. Any partially sent byte completes inside uart_tx and is not retried.
- States: IDLE, GET_KEY, GET_PT, START, WAIT_CORE, SEND, SEND_HI, SEND_LO.
- IDLE: on rx_valid, opcode CMD_KEY -> GET_KEY; CMD_ENC -> GET_PT if key_loaded=1, else queue NAK 8'h15 -> SEND. Any other opcode -> frame_err pulse and queue NAK 8'h15 -> SEND.
- GET_KEY / GET_PT: each rx_valid shifts rx_data into the LSB of the target register (register <= {register[..-8], rx_data}), so the first byte received ends up in the MSB. The counter increments per byte.
  - Key frame ends after KEY_BYTES bytes: key_loaded<=1, queue ACK 8'h06 -> SEND. The key is updated in place; a partial key frame leaves core_key corrupted and clears key_loaded.
  - Plaintext frame ends after BLOCK_BYTES bytes -> START.
- Timeout: counter cleared on each rx_valid, increments otherwise in GET_KEY/GET_PT. Reaching TIMEOUT_CYC -> frame_err pulse, back to IDLE, no reply.
- START: core_start=1 for exactly one cycle -> WAIT_CORE.
- WAIT_CORE: on core_done, latch core_ct into the shift register, count=BLOCK_BYTES -> SEND. No timeout. rx_valid is ignored (dropped) in every state from START through SEND_LO.
- SEND: when tx_busy=0, drive tx_data=MSB byte and tx_valid=1 for one cycle -> SEND_HI. While tx_busy=1, wait.
- SEND_HI: wait for tx_busy=1, then -> SEND_LO.
- SEND_LO: wait for tx_busy=0. Then shift the register left 8 and decrement count. count=0 -> IDLE, else -> SEND. ACK/NAK replies are single-byte sends (count=1).
- tx_valid is never asserted while tx_busy=1 and never two cycles in a row.
- Simultaneous rx_valid and timeout terminal count: the byte wins and the counter clears.
- Latency: core_start follows the last plaintext rx_valid by 2 cycles. The first tx_valid follows core_done by 2 cycles when tx_busy=0.

Test Plan:
- Reset: hold rst=0, then release -> all outputs 0, busy=0. Assert rst=0 during SEND_LO -> outputs return to 0 within the same cycle, with no clock edge required.
- Key load: send 4B,1B,1A,19,18,13,12,11,10,0B,0A,09,08,03,02,01,00 -> core_key=1b1a1918_13121110_0b0a0908_03020100, key_loaded=1, single tx byte 06.
- Encrypt: send 45,3B,72,65,74,74,75,43,2D -> core_pt=3b726574_7475432d, one core_start pulse. The core model returns 8c6fa548_454e028b, and tx emits 8C,6F,A5,48,45,4E,02,8B in order, with every tx_valid while tx_busy=0. Full uart_tx/uart_rx loopback at 115200 recovers those bytes.
- Encrypt without a key, after reset: send 45 -> tx byte 15, no core_start. Unknown opcode 5A -> frame_err pulse, tx byte 15.
- Timeout: TIMEOUT_CYC=1000, send 45,3B,72 then idle 1000 cycles -> frame_err pulse, state IDLE, no core_start. A following full encrypt frame succeeds.
- Back-pressure: hold tx_busy=1 for 500 cycles in SEND -> tx_valid stays 0, bytes are sent in order after release. Bytes arriving during WAIT_CORE are dropped without corrupting the output.
